dmem_access_ctrl: RTL and testbench
===================================

Name: dmem_access_ctrl

Overview:
- Sequences every load/store between the single-cycle core datapath and the data-memory bus.
- Datapath inputs: effective address (ALU output), store data (rd2), opcode and funct3.
- Datapath outputs: pc_enable, reg_write_load and the formatted load result ReadDDT.
- Handles byte-lane steering, sign/zero extension and misalignment detection, and stalls the core through a req/ready handshake with timeout.

Parameters:
- TIMEOUT, 255: maximum WAIT cycles before a bus error is declared; 8-bit counter, legal range 1..255.
- LOAD_OP, 7'b0000011: load opcode.
- STORE_OP, 7'b0100011: store opcode.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- opcode  in  7  inst[6:0] of the current instruction.
- funct3  in  3  inst[14:12].
- addr  in  32  effective address (ALU result).
- wdata  in  32  store data (rd2).
- mem_rdata  in  32  bus read word, valid when mem_ready=1.
- mem_ready  in  1  bus completion strobe.
- mem_req  out  1  bus request, registered.
- mem_we  out  1  1 = write, registered.
- mem_addr  out  32  word-aligned address ({addr[31:2],2'b00}), registered.
- mem_be  out  4  byte enables, registered.
- mem_wdata  out  32  lane-steered store data, registered.
- read_ddt  out  32  formatted load result, registered.
- pc_enable  out  1  1 = PC may advance this cycle.
- reg_write_load  out  1  register-file write qualifier; equals pc_enable.
- mem_err  out  1  sticky fault flag.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - mem_req, mem_we, mem_err = 0; mem_be = 4'b0000; mem_addr, mem_wdata, read_ddt = 0; timeout counter = 0.
  - pc_enable and reg_write_load are forced 0 while rst=0.
- Memory op = opcode equals LOAD_OP or STORE_OP.
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
- Misaligned:
  - Halfword access with addr[0]=1.
  - Word access with addr[1:0]≠00.
- State IDLE:
  - Non-memory op: pc_enable=1, stay in IDLE.
  - Memory op that is legal and aligned: pc_enable=0; next edge goes to WAIT and registers mem_req=1, mem_we=(store), mem_addr, mem_be, mem_wdata; counter cleared.
  - Illegal funct3 or misaligned: pc_enable=0; next edge goes to ERR; no bus request is issued.
  - mem_ready is ignored in IDLE.
- State WAIT:
  - pc_enable=0; mem_req and all bus outputs held stable.
  - mem_ready=1: next edge goes to DONE, mem_req←0, and for a load read_ddt←formatted mem_rdata.
  - Otherwise the counter increments. If the counter equals TIMEOUT-1 on a cycle with mem_ready=0, next edge goes to ERR with mem_req←0.
- State DONE: pc_enable=1 for exactly one cycle (the instruction retires), then IDLE. Because the PC advances on this edge, IDLE sees the next instruction and a store is never re-issued.
- State ERR: mem_err=1 (sticky), pc_enable=0, mem_req=0; exits only by reset.
- Store steering, with b = addr[1:0]:
  - SB: mem_wdata = {4{wdata[7:0]}}, mem_be = 1<<b.
  - SH: mem_wdata = {2{wdata[15:0]}}, mem_be = 0011 if addr[1]=0, else 1100.
  - SW: mem_wdata = wdata, mem_be = 1111.
- Load formatting:
  - Select byte lane b, or halfword lane addr[1].
  - LB/LH sign-extend to 32 bits; LBU/LHU zero-extend; LW passes the word through.
  - For loads mem_be = the same mask as the store of equal width.
  - read_ddt holds its value until the next load completes.
- Latency:
  - Memory op with mem_ready on the first WAIT cycle = 3 cycles (IDLE, WAIT, DONE).
  - Each additional wait cycle adds 1.
  - Non-memory op = 1 cycle.
- Reset mid-WAIT: mem_req drops asynchronously and the transaction is abandoned; no partial read_ddt update.

Test Plan:
- Non-memory op (opcode 0110011) held for 5 cycles after reset release -> pc_enable=1 every cycle, mem_req never asserted.
- LB, addr=0x1003, mem_rdata=0x80FF_FF00, ready on the first WAIT cycle -> mem_addr=0x1000, mem_be=1000, read_ddt=0xFFFF_FF80; pc_enable pattern 0,0,1.
- SH, addr=0x2002, wdata=0x1234_ABCD, ready after 3 waits -> mem_we=1, mem_be=1100, mem_wdata=0xABCD_ABCD; pc_enable=0 for 5 cycles then 1.
- LW, addr=0x0006 -> ERR: mem_req stays 0, mem_err=1, pc_enable=0 until rst pulse; after reset mem_err=0.
- LHU, TIMEOUT=4, mem_ready never asserted -> mem_req high for exactly 4 cycles, then mem_req=0, mem_err=1.
- Load in WAIT with rst pulsed low mid-wait -> mem_req=0 immediately, read_ddt=0, state IDLE after reset release.

Source files
------------

// File: rtl/dmem_access_ctrl.sv
// Load/store sequencer between the single-cycle core and the data-memory bus:
// lane steering, load extension, misalignment trap and a req/ready handshake with timeout.
module dmem_access_ctrl #(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [6:0]  LOAD_OP  = 7'b0000011,
  parameter logic [6:0]  STORE_OP = 7'b0100011
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  output logic [31:0] read_ddt,
  output logic        pc_enable,
  output logic        reg_write_load,
  output logic        mem_err
);

  // state | meaning
  // IDLE  | decode current instruction, retire non-memory ops
  // WAIT  | bus request outstanding, counting toward timeout
  // DONE  | memory op retires (pc_enable for one cycle)
  // ERR   | sticky fault, core frozen until reset
  typedef enum logic [1:0] {IDLE, WAIT, DONE, ERR} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        req_q, req_d, we_q, we_d, err_q, err_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, ddt_q, ddt_d;
  logic [3:0]  be_q, be_d;
  logic [2:0]  fn_q, fn_d;
  logic [1:0]  off_q, off_d;

  logic        is_load, is_store, legal, misal, pc_raw;
  logic [3:0]  be_new;
  logic [31:0] wdata_new, shifted, fmt;
  logic [15:0] half;

  assign is_load  = (opcode == LOAD_OP);
  assign is_store = (opcode == STORE_OP);
  assign legal    = is_load ? (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
                            : (funct3 inside {3'b000, 3'b001, 3'b010});
  assign misal    = ((funct3[1:0] == 2'b01) && addr[0]) ||
                    ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));

  always_comb begin
    be_new    = 4'b1111;
    wdata_new = wdata;
    case (funct3[1:0])
      2'b00: begin
        be_new    = 4'b0001 << addr[1:0];
        wdata_new = {4{wdata[7:0]}};
      end
      2'b01: begin
        be_new    = addr[1] ? 4'b1100 : 4'b0011;
        wdata_new = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Lane selection uses the offset captured at issue, not the live address.
  always_comb begin
    shifted = mem_rdata >> {off_q, 3'b000};
    half    = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (fn_q)
      3'b000:  fmt = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  fmt = {{16{half[15]}}, half};
      3'b100:  fmt = {24'd0, shifted[7:0]};
      3'b101:  fmt = {16'd0, half};
      default: fmt = mem_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    ddt_d   = ddt_q;
    err_d   = err_q;
    fn_d    = fn_q;
    off_d   = off_q;
    pc_raw  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!(is_load || is_store)) begin
          pc_raw = 1'b1;
        end else if (legal && !misal) begin
          state_d = WAIT;
          req_d   = 1'b1;
          we_d    = is_store;
          addr_d  = {addr[31:2], 2'b00};
          be_d    = be_new;
          wdata_d = wdata_new;
          cnt_d   = 8'd0;
          fn_d    = funct3;
          off_d   = addr[1:0];
        end else begin
          state_d = ERR;
          err_d   = 1'b1;
        end
      end
      WAIT: begin
        if (mem_ready) begin
          state_d = DONE;
          req_d   = 1'b0;
          if (!we_q) ddt_d = fmt;
        end else if (cnt_q == TO_LAST) begin
          state_d = ERR;
          req_d   = 1'b0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE: begin
        pc_raw  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        err_d = 1'b1;
        req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      be_q    <= 4'b0000;
      wdata_q <= 32'd0;
      ddt_q   <= 32'd0;
      err_q   <= 1'b0;
      fn_q    <= 3'b000;
      off_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      ddt_q   <= ddt_d;
      err_q   <= err_d;
      fn_q    <= fn_d;
      off_q   <= off_d;
    end
  end

  assign mem_req        = req_q;
  assign mem_we         = we_q;
  assign mem_addr       = addr_q;
  assign mem_be         = be_q;
  assign mem_wdata      = wdata_q;
  assign read_ddt       = ddt_q;
  assign mem_err        = err_q;
  assign pc_enable      = pc_raw & rst;
  assign reg_write_load = pc_enable;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: per-cycle comparison against a transaction-level
// model of steering, extension, latency and fault behaviour.
module tb_dmem_access_ctrl;
  localparam int TO = 4;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_R  = 7'b0110011;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [6:0]  opcode = OP_R;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = 32'd0, wdata = 32'd0, mem_rdata = 32'd0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_we, pc_enable, reg_write_load, mem_err;
  logic [31:0] mem_addr, mem_wdata, read_ddt;
  logic [3:0]  mem_be;

  int tests = 0;
  int fails = 0;

  logic        chk = 1'b0;
  logic        e_pc = 1'b0, e_req = 1'b0, e_we = 1'b0, e_err = 1'b0;
  logic [31:0] e_addr = 32'd0, e_wdata = 32'd0, e_ddt = 32'd0;
  logic [3:0]  e_be = 4'd0;

  always #5 clk = ~clk;

  dmem_access_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .addr(addr),
    .wdata(wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .read_ddt(read_ddt), .pc_enable(pc_enable),
    .reg_write_load(reg_write_load), .mem_err(mem_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Access model: width in bytes, lane offset, masks built arithmetically.
  function automatic int nbytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic int lane_of(input logic [2:0] f3, input logic [31:0] a);
    int n = nbytes(f3);
    return int'(a % 4) - int'(a % 4) % n;
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
    logic [7:0] m = 8'((1 << nbytes(f3)) - 1);
    m = m << lane_of(f3, a);
    return m[3:0];
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
    int n = nbytes(f3);
    logic [63:0] mask = (64'd1 << (8 * n)) - 1;
    logic [63:0] w = {32'd0, wd} & mask;
    logic [63:0] r = 64'd0;
    for (int k = 0; k < 4 / n; k++) r = r | (w << (8 * n * k));
    return r[31:0];
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rd);
    int n = nbytes(f3);
    logic [63:0] mask = (64'd1 << (8 * n)) - 1;
    logic [63:0] v = ({32'd0, rd} >> (8 * lane_of(f3, a))) & mask;
    if (!f3[2] && n < 4 && v[8 * n - 1]) v = v | ~mask;
    return v[31:0];
  endfunction

  function automatic bit model_ok(input logic [6:0] opc, input logic [2:0] f3,
                                  input logic [31:0] a);
    bit lg = (opc == OP_LD) ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})
                            : (f3 inside {3'd0, 3'd1, 3'd2});
    return lg && (a % nbytes(f3) == 0);
  endfunction

  always @(negedge clk) begin
    if (chk) begin
      check("pc_enable", {31'd0, pc_enable}, {31'd0, e_pc});
      check("reg_write_load", {31'd0, reg_write_load}, {31'd0, e_pc});
      check("mem_req", {31'd0, mem_req}, {31'd0, e_req});
      check("mem_err", {31'd0, mem_err}, {31'd0, e_err});
      check("read_ddt", read_ddt, e_ddt);
      if (e_req) begin
        check("mem_we", {31'd0, mem_we}, {31'd0, e_we});
        check("mem_addr", mem_addr, e_addr);
        check("mem_be", {28'd0, mem_be}, {28'd0, e_be});
        check("mem_wdata", mem_wdata, e_wdata);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic nonmem(input int n);
    opcode = OP_R; funct3 = 3'b000; mem_ready = 1'b1;
    chk = 1'b1; e_pc = 1'b1; e_req = 1'b0;
    repeat (n) step();
    mem_ready = 1'b0;
  endtask

  // nwait = cycles in WAIT before mem_ready; nwait >= TO never responds.
  task automatic mem_op(input logic [6:0] opc, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rd, input int nwait);
    int waits;
    opcode = opc; funct3 = f3; addr = a; wdata = wd;
    mem_ready = 1'b0; mem_rdata = 32'hDEAD_BEEF;
    chk = 1'b1; e_pc = 1'b0; e_req = 1'b0;
    if (!model_ok(opc, f3, a)) begin
      step();
      e_err = 1'b1;
      repeat (3) step();
    end else begin
      step();
      e_req = 1'b1; e_we = (opc == OP_ST); e_addr = a & ~32'd3;
      e_be = model_be(f3, a); e_wdata = model_wdata(f3, wd);
      waits = (nwait < TO) ? nwait + 1 : TO;
      for (int i = 0; i < waits; i++) begin
        mem_ready = (i == nwait);
        mem_rdata = mem_ready ? rd : 32'hDEAD_BEEF;
        step();
      end
      mem_ready = 1'b0; mem_rdata = 32'hDEAD_BEEF;
      e_req = 1'b0;
      if (nwait < TO) begin
        e_pc = 1'b1;
        if (opc == OP_LD) e_ddt = model_load(f3, a, rd);
        step();
        e_pc = 1'b0;
      end else begin
        e_err = 1'b1;
        repeat (3) step();
      end
    end
  endtask

  // Asserts reset mid-cycle, checks the asynchronous effect, releases after the next edge.
  task automatic do_reset();
    chk = 1'b0;
    #2;
    rst = 1'b0;
    opcode = OP_R;
    #1;
    check("rst_req", {31'd0, mem_req}, 32'd0);
    check("rst_err", {31'd0, mem_err}, 32'd0);
    check("rst_pc", {31'd0, pc_enable}, 32'd0);
    check("rst_ddt", read_ddt, 32'd0);
    e_ddt = 32'd0; e_err = 1'b0; e_req = 1'b0; e_pc = 1'b0;
    step();
    rst = 1'b1;
  endtask

  initial begin
    #2;
    check("reset_be", {28'd0, mem_be}, 32'd0);
    check("reset_addr", mem_addr, 32'd0);
    check("reset_wdata", mem_wdata, 32'd0);
    check("reset_pc", {31'd0, pc_enable}, 32'd0);
    check("pin_lb", model_load(3'b000, 32'h1003, 32'h80FF_FF00), 32'hFFFF_FF80);
    check("pin_sh_wd", model_wdata(3'b001, 32'h1234_ABCD), 32'hABCD_ABCD);
    check("pin_sh_be", {28'd0, model_be(3'b001, 32'h2002)}, 32'h0000_000C);
    check("pin_lhu", model_load(3'b101, 32'h0102, 32'hBEEF_1234), 32'h0000_BEEF);
    step();
    rst = 1'b1;

    nonmem(5);
    mem_op(OP_LD, 3'b000, 32'h1003, 32'h0, 32'h80FF_FF00, 0);
    check("lb_ddt", read_ddt, 32'hFFFF_FF80);
    check("lb_addr", mem_addr, 32'h0000_1000);
    check("lb_be", {28'd0, mem_be}, 32'h0000_0008);
    mem_op(OP_ST, 3'b001, 32'h2002, 32'h1234_ABCD, 32'h0, 3);
    check("sh_wdata", mem_wdata, 32'hABCD_ABCD);
    check("sh_be", {28'd0, mem_be}, 32'h0000_000C);
    check("sh_we", {31'd0, mem_we}, 32'd1);
    check("sh_ddt_held", read_ddt, 32'hFFFF_FF80);
    mem_op(OP_LD, 3'b101, 32'h0102, 32'h0, 32'hBEEF_1234, 1);
    mem_op(OP_LD, 3'b001, 32'h0100, 32'h0, 32'h0000_8001, 0);
    check("lh_ddt", read_ddt, 32'hFFFF_8001);
    mem_op(OP_LD, 3'b100, 32'h0005, 32'h0, 32'h0000_9A00, 2);
    check("lbu_ddt", read_ddt, 32'h0000_009A);
    mem_op(OP_ST, 3'b000, 32'h0011, 32'hCAFE_0055, 32'h0, 0);
    check("sb_be", {28'd0, mem_be}, 32'h0000_0002);
    mem_op(OP_ST, 3'b010, 32'h0020, 32'h0BAD_F00D, 32'h0, 0);
    mem_op(OP_LD, 3'b010, 32'h0024, 32'h0, 32'h7654_3210, 1);
    nonmem(2);

    mem_op(OP_LD, 3'b010, 32'h0006, 32'h0, 32'h0, 0);
    check("misal_err", {31'd0, mem_err}, 32'd1);
    do_reset();
    nonmem(1);
    check("misal_err_cleared", {31'd0, mem_err}, 32'd0);

    mem_op(OP_LD, 3'b011, 32'h0000, 32'h0, 32'h0, 0);
    do_reset();
    nonmem(1);

    mem_op(OP_LD, 3'b101, 32'h0040, 32'h0, 32'h0, 100);
    check("timeout_err", {31'd0, mem_err}, 32'd1);
    do_reset();
    nonmem(1);

    mem_op(OP_LD, 3'b010, 32'h0030, 32'h0, 32'h1111_2222, 0);
    opcode = OP_LD; funct3 = 3'b010; addr = 32'h0034;
    mem_ready = 1'b0; chk = 1'b1; e_pc = 1'b0; e_req = 1'b0;
    step();
    e_req = 1'b1; e_we = 1'b0; e_addr = 32'h0034; e_be = 4'b1111; e_wdata = 32'd0;
    step();
    do_reset();
    nonmem(2);
    check("post_abort_ddt", read_ddt, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
